lu_resp: RTL and testbench
==========================

LU_RESP -- requirements
Module: lu_resp

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request may be accepted this cycle.
REQ-006 SHALL have ports a, b  input  W  operands.
REQ-007 SHALL have port op  input  2  operation select.
REQ-008 SHALL have port out_valid  output  1  response present.
REQ-009 SHALL have port out_ready  input  1  consumer takes response this cycle.
REQ-010 SHALL have port y  output  W  result.
REQ-011 SHALL have port y_op  output  2  op echoed with result.

Function
REQ-012 SHALL accept a request on a rising edge when in_valid=1 and in_ready=1 (push).
REQ-013 SHALL retire a response on a rising edge when out_valid=1 and out_ready=1 (pop).
REQ-014 SHALL compute the result at push: op 00 a&b, 01 a|b, 10 a^b, 11 ~(a|b), all W bits, no carry.
REQ-015 SHALL hold results in a 2-entry FIFO, states EMPTY, ONE, FULL.
REQ-016 SHALL make latency exactly 1 cycle: a push at edge N makes out_valid=1 after edge N when the FIFO was EMPTY.
REQ-017 SHALL drive in_ready=1 in EMPTY and ONE and 0 in FULL; no same-cycle pass-through when FULL.
REQ-018 SHALL drive out_valid=1 in ONE and FULL and 0 in EMPTY.
REQ-019 SHALL present y/y_op of the oldest entry; they are stable while out_valid=1 and out_ready=0.
REQ-020 SHALL make transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE, new entry at head next cycle; FULL+pop->ONE; otherwise hold.
REQ-021 SHALL wrap the read/write pointers modulo 2 with no loss or duplication.
REQ-022 SHALL ignore a, b and op when in_valid=0 or in_ready=0, including X values.

Reset
REQ-023 SHALL on rst=1, immediately and without clk, force EMPTY, out_valid=0, in_ready=0, y=0, y_op=00, pointers=0.
REQ-024 SHALL discard any buffered entries when reset is asserted mid-operation.
REQ-025 SHALL raise in_ready to 1 on the first rising clk edge after rst deasserts.

Configuration
REQ-026 SHALL, with macro LU_RESP_STATS_EN defined, add output port stat_cnt (16 bits), reset to 0, incrementing by 1 on every pop and wrapping from 0xFFFF to 0x0000.
REQ-027 SHALL, without LU_RESP_STATS_EN, omit the stat_cnt port and its counter; all other behaviour is identical.

Structure
REQ-028 SHALL take op encodings (OP_AND=00, OP_OR=01, OP_XOR=10, OP_NOR=11) and the FIFO state encoding from shared package lu_pkg.
REQ-029 SHALL implement storage and occupancy in sub-module lu_fifo2 (depth 2, width W+2); operation decode stays in lu_resp.

Verification
REQ-030 SHALL cover single op: a=00000001, b=00001000, op=01, out_ready=1 -> one cycle later out_valid=1, y=00001001, y_op=01.
REQ-031 SHALL cover all ops back-to-back: a=00000001, b=00001000, op 00..11 on consecutive cycles -> y = 00000000, 00001001, 00001001, 11110110 in order.
REQ-032 SHALL cover backpressure: out_ready=0, three pushes offered -> first two accepted, in_ready=0 after the second push, y holds the first result; out_ready=1 -> results drain in order and the third request is then accepted.
REQ-033 SHALL cover simultaneous push+pop in ONE -> state stays ONE, no entry lost, order kept.
REQ-034 SHALL cover reset mid-operation: rst asserted while FULL -> out_valid=0 and y=0 immediately, without waiting for clk; no stale result after release.
REQ-035 SHALL cover X inputs: a, b, op = X with in_valid=0 -> state, y and y_op unchanged; with LU_RESP_STATS_EN, 65536 pops -> stat_cnt=0.

Source files
------------

// File: rtl/lu_pkg.sv
// ============================================================================
// Module      : lu_pkg
// Description : Shared definitions for the lu_resp logic-unit responder:
//               operation encodings, FIFO occupancy state encoding and the
//               occupancy next-state helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lu_pkg;

    // Operation select encodings
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    // Two-entry FIFO occupancy states
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    // Occupancy transition. The push/pop arguments must already be qualified
    // by the corresponding handshake (no push in FULL, no pop in EMPTY).
    function automatic logic [1:0] lu_next_state(input logic [1:0] state,
                                                 input logic       push,
                                                 input logic       pop);
        logic [1:0] nxt;
        nxt = state;
        case (state)
            ST_EMPTY: if (push) nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      nxt = ST_FULL;
                else if (!push && pop) nxt = ST_EMPTY;
                else                   nxt = ST_ONE;
            end
            ST_FULL:  if (pop) nxt = ST_ONE;
            default:  nxt = ST_EMPTY;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lu_fifo2.sv
// ============================================================================
// Module      : lu_fifo2
// Description : Two-entry FIFO with EMPTY/ONE/FULL occupancy tracking.
//               Head entry is presented combinationally; reads zero when empty.
// Ports       : clk, rst (async, active-high)
//               push, wdata        - write side (push qualified internally)
//               ready              - write may be accepted this cycle
//               pop                - read side (pop qualified internally)
//               valid, rdata       - head entry present / head entry
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lu_fifo2
    import lu_pkg::*;
#(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] rdata
);

    logic [1:0]    state;
    logic          wptr;
    logic          rptr;
    logic [DW-1:0] mem [2];
    // Held low through reset so the write side only opens on the first
    // clock edge after reset is released.
    logic          rst_done;

    logic          do_push;
    logic          do_pop;

    assign ready   = (state != ST_FULL) && rst_done;
    assign valid   = (state != ST_EMPTY);
    assign do_push = push && ready;
    assign do_pop  = pop && valid;

    // Masking with valid keeps the read port at zero while empty, so nothing
    // stale is ever visible after a pop-to-empty or a reset.
    assign rdata   = valid ? mem[rptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            state    <= lu_next_state(state, do_push, do_pop);
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lu_resp.sv
// ============================================================================
// Module      : lu_resp
// Description : Logic-unit responder. Computes a bitwise op on a/b when a
//               request is accepted and returns the result (with the op
//               echoed) through a two-entry response FIFO, latency 1 cycle.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready, a, b, op   - request channel
//               out_valid/out_ready, y, y_op  - response channel
//               stat_cnt (16b)                - pop counter, only when the
//                                               macro LU_RESP_STATS_EN is
//                                               defined
// Parameters  : W - operand/result width
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lu_resp
    import lu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic [1:0]   y_op
`ifdef LU_RESP_STATS_EN
    ,
    output logic [15:0]  stat_cnt
`endif
);

    logic [W-1:0] result;
    logic [W+1:0] rdata;

    // Operation decode; its output is only sampled on an accepted push, so
    // X on a/b/op outside a handshake never reaches state.
    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            default: result = '0;
        endcase
    end

    lu_fifo2 #(
        .DW (W + 2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata ({op, result}),
        .ready (in_ready),
        .pop   (out_ready),
        .valid (out_valid),
        .rdata (rdata)
    );

    assign y    = rdata[W-1:0];
    assign y_op = rdata[W+1:W];

`ifdef LU_RESP_STATS_EN
    logic pop;
    assign pop = out_valid && out_ready;

    // Free-running pop counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt <= 16'h0000;
        end else if (pop) begin
            stat_cnt <= stat_cnt + 16'h0001;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lu_resp.sv
// ============================================================================
// Module      : tb_lu_resp
// Description : Self-checking bench for lu_resp. Directed steps drive the
//               request/response channels; a queue scoreboard holds expected
//               {y_op, y} entries pushed on accepted requests and compared
//               at the head every cycle. Stats checks build with
//               LU_RESP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lu_resp;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [1:0]   y_op;
`ifdef LU_RESP_STATS_EN
    logic [15:0]  stat_cnt;
    logic [15:0]  exp_stat;
`endif

    int errors = 0;
    int checks = 0;

    logic [W+1:0] q [$];
    bit           rdy_ok;
    int           pops_total;
    int           pushes_total;

    lu_resp #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_op      (y_op)
`ifdef LU_RESP_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] ma,
                                           input logic [W-1:0] mb,
                                           input logic [1:0]   mop);
        case (mop)
            2'b00:   return ma & mb;
            2'b01:   return ma | mb;
            2'b10:   return ma ^ mb;
            default: return ~(ma | mb);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Check outputs against the model, then advance one clock edge and
    // update the scoreboard with whatever handshakes the model predicts.
    task automatic tick();
        logic [W-1:0] ca, cb;
        logic [1:0]   cop;
        bit           push, pop;
        chk("out_valid", {31'b0, out_valid}, {31'b0, (q.size() != 0)});
        chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2 && rdy_ok)});
        if (q.size() != 0) begin
            chk("y", {24'b0, y}, {24'b0, q[0][W-1:0]});
            chk("y_op", {30'b0, y_op}, {30'b0, q[0][W+1:W]});
        end
`ifdef LU_RESP_STATS_EN
        chk("stat_cnt", {16'b0, stat_cnt}, {16'b0, exp_stat});
`endif
        push = (in_valid === 1'b1) && (q.size() < 2) && rdy_ok;
        pop  = (q.size() != 0) && (out_ready === 1'b1);
        ca = a; cb = b; cop = op;
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q.pop_front());
            pops_total++;
`ifdef LU_RESP_STATS_EN
            exp_stat = exp_stat + 16'h0001;
`endif
        end
        if (push) begin
            q.push_back({cop, model(ca, cb, cop)});
            pushes_total++;
        end
        rdy_ok = 1'b1;
    endtask

    task automatic model_reset();
        q.delete();
        rdy_ok = 1'b0;
`ifdef LU_RESP_STATS_EN
        exp_stat = 16'h0000;
`endif
    endtask

    task automatic drive(input logic v, input logic [W-1:0] da,
                         input logic [W-1:0] db, input logic [1:0] dop);
        in_valid = v; a = da; b = db; op = dop;
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; op = 2'b00; out_ready = 1'b0;
        pops_total = 0; pushes_total = 0;
        model_reset();

        // Reset is asynchronous: outputs settle before any clock edge.
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_y", {24'b0, y}, 32'd0);
        chk("rst_y_op", {30'b0, y_op}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // in_ready stays low until the first edge after release (checked in tick).
        tick();

        // Single op: OR -> 0x09, one cycle latency.
        out_ready = 1'b1;
        drive(1'b1, 8'h01, 8'h08, 2'b01);
        tick();
        drive(1'b0, 8'h00, 8'h00, 2'b00);
        chk("single_valid", {31'b0, out_valid}, 32'd1);
        chk("single_y", {24'b0, y}, 32'h09);
        chk("single_y_op", {30'b0, y_op}, 32'd1);
        tick();
        tick();

        // All ops back to back; push+pop in ONE keeps order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h01, 8'h08, i[1:0]);
            tick();
            chk("b2b_valid", {31'b0, out_valid}, 32'd1);
            chk("b2b_y", {24'b0, y}, (i == 0) ? 32'h00 : (i == 3) ? 32'hF6 : 32'h09);
        end
        drive(1'b0, 8'h00, 8'h00, 2'b00);
        tick();
        tick();

        // Backpressure: two accepted, third held off while FULL.
        out_ready = 1'b0;
        drive(1'b1, 8'hA5, 8'h3C, 2'b00);
        tick();
        drive(1'b1, 8'hA5, 8'h3C, 2'b10);
        tick();
        chk("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_head_y", {24'b0, y}, 32'h24);
        drive(1'b1, 8'h0F, 8'hF0, 2'b11);
        repeat (3) tick();
        out_ready = 1'b1;
        guard = 0;
        while (pushes_total < 14 && guard < 10) begin
            tick();
            guard++;
        end
        chk("bp_third_accepted", {31'b0, (pushes_total >= 14)}, 32'd1);
        drive(1'b0, 8'h00, 8'h00, 2'b00);
        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            tick();
            guard++;
        end
        chk("bp_drained", {31'b0, (q.size() == 0)}, 32'd1);
        tick();

        // X on request inputs with in_valid=0 leaves everything unchanged.
        out_ready = 1'b0;
        drive(1'b1, 8'h5A, 8'hC3, 2'b10);
        tick();
        in_valid = 1'b0; a = 'x; b = 'x; op = 'x;
        repeat (3) tick();
        chk("x_hold_y", {24'b0, y}, 32'h99);
        chk("x_hold_y_op", {30'b0, y_op}, 32'd2);

        // Reset while FULL: outputs clear without a clock edge.
        drive(1'b1, 8'h12, 8'h34, 2'b01);
        tick();
        chk("pre_rst_full", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_y", {24'b0, y}, 32'd0);
        chk("midrst_y_op", {30'b0, y_op}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_no_stale", {31'b0, out_valid}, 32'd0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 2'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

`ifdef LU_RESP_STATS_EN
        // 65536 pops from reset wrap the counter back to zero.
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        pops_total = 0;
        pushes_total = 0;
        out_ready = 1'b1;
        guard = 0;
        while (pops_total < 65536 && guard < 70000) begin
            drive((pushes_total < 65536) ? 1'b1 : 1'b0, 8'hFF, 8'h0F, 2'b10);
            tick();
            guard++;
        end
        chk("stat_pops_done", {31'b0, (pops_total == 65536)}, 32'd1);
        chk("stat_wrap", {16'b0, stat_cnt}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
